regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-read-port integer register file with per-register busy scoreboard and a hardware zeroing sweep. It succeeds the single-cycle core's 2-read/1-write register file. It sits in the decode stage of the pipelined core: issue reserves destinations, writeback writes and releases them, and decode reads operands plus busy status. The sweep lets software or the debug unit re-zero the file without asserting core reset.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥4)
- NRD, 2, number of read ports
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- rd_addr  input  NRD*AW  read addresses, port k at [k*AW +: AW]
- rd_data  output  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rd_busy  output  NRD  busy bit for each read address
- wr_en  input  1  writeback write enable
- wr_addr  input  AW  writeback address
- wr_data  input  XLEN  writeback data
- rsv_en  input  1  issue reservation enable
- rsv_addr  input  AW  register being reserved
- init_req  input  1  pulse: start zeroing sweep
- init_busy  output  1  high while sweep in progress

## Operation
- Register 0 reads 0 and is never busy. Writes and reservations to address 0 are dropped.
- Write: wr_en && wr_addr!=0 stores wr_data and clears busy[wr_addr].
- Reserve: rsv_en && rsv_addr!=0 sets busy[rsv_addr].
- Same-cycle write and reserve, same address: data is written and busy ends at 1 (the reservation wins).
- Reads are combinational from the array and busy vector. Each port is independent, and any ports may share an address.
- FSM states are IDLE and SWEEP.
  - IDLE → SWEEP on init_req. Counter loads 1.
  - In SWEEP, each cycle writes 0 to reg[cnt], clears busy[cnt], and increments cnt.
  - SWEEP → IDLE after writing reg[NREGS-1].
- During SWEEP: init_busy=1, wr_en and rsv_en are ignored (dropped, not queued), and init_req is ignored. Reads return current array contents, so partially swept values are visible.
- Reset (any state): all registers 0, all busy 0, FSM IDLE, cnt 0. A reset mid-sweep aborts the sweep immediately.

## Timing
- Reset values: rd_data = contents (all 0 after reset), rd_busy 0, init_busy 0.
- Read latency is 0 cycles (combinational from address).
- Write and busy update are visible on read ports the cycle after the edge, unless bypass is compiled in (see Configuration).
- Sweep length is NREGS-1 cycles.
  - init_busy rises the cycle after init_req is sampled and falls the cycle after the last write.
  - Example: NREGS=32 gives init_busy high for exactly 31 cycles.
- Reservation to visible rd_busy=1 takes 1 cycle. It is never bypassed.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: a read port whose address equals wr_addr while wr_en=1, wr_addr!=0 and FSM=IDLE returns wr_data in the same cycle. The same port also reports rd_busy=0, unless a same-cycle reservation targets that address.
- Undefined: no forwarding. Reads return stored contents and the new value appears next cycle. The decode stage then handles the 1-cycle hazard.

## Structure
- Package regfile_pkg holds:
  - default XLEN/NREGS constants
  - the FSM state enum (RF_IDLE, RF_SWEEP)
  - a function extracting port k from the packed address and data buses
- Sub-module regfile_scoreboard holds the NREGS-bit busy vector, set/clear priority and the NRD busy lookups. Data array, FSM and bypass muxing stay in regfile_sb.

## Test plan
- Reset, then write 0xDEADBEEF to r5 and read r5 on both ports next cycle → 0xDEADBEEF on both. Write to r0 → r0 still reads 0.
- Reserve r7, then read r7 → rd_busy=1. Write r7=0x1234 → next cycle rd_busy=0 and data 0x1234. Same-cycle write+reserve on r7 → busy stays 1 and data is updated.
- Fill r1..r31 with nonzero values and reserve several; pulse init_req → init_busy high 31 cycles, and afterwards all reads are 0 with busy 0. A wr_en to r3 issued mid-sweep is dropped.
- Start sweep, assert reset at sweep cycle 10 → next cycle init_busy=0 and all registers 0. A later init_req starts a fresh 31-cycle sweep.
- With REGFILE_BYPASS_EN: wr_en to r9 with 0xCAFEF00D while reading r9 → same-cycle rd_data=0xCAFEF00D and rd_busy=0. Without the macro, the same stimulus returns the old value until the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and bus-slicing helper for the regfile_sb register file.
// The optional same-cycle write forwarding is compiled in with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    // Widest packed bus / field the slicing helper accepts.
    localparam int unsigned BUS_W   = 1024;
    localparam int unsigned FIELD_W = 64;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

    // Returns field k of width w from a packed bus of equal-width fields.
    function automatic logic [FIELD_W-1:0] port_field(
        input logic [BUS_W-1:0] bus,
        input int unsigned      k,
        input int unsigned      w
    );
        logic [BUS_W-1:0]   shifted;
        logic [FIELD_W-1:0] mask;
        shifted = bus >> (k * w);
        mask    = {FIELD_W{1'b1}} >> (FIELD_W - w);
        return shifted[FIELD_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservations set, writebacks/sweep clear, set wins a tie.
// Register 0 is never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    always_comb begin
        rd_busy = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_busy[k] = busy_q[AW'(port_field(BUS_W'(rd_addr), k, AW))];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with busy scoreboard and a hardware zeroing sweep.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback onto matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN  = XLEN_DEF,
    parameter  int unsigned NREGS = NREGS_DEF,
    parameter  int unsigned NRD   = 2,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                init_req,
    output logic                init_busy
);

    rf_state_e       state_q;
    logic [AW-1:0]   cnt_q;
    logic            init_busy_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NRD-1:0]  busy_raw;

    logic sweeping;
    logic wr_ok;
    logic rsv_ok;
    logic last_cnt;

    // Writeback and issue traffic is dropped, not queued, while sweeping.
    assign sweeping = (state_q == RF_SWEEP);
    assign wr_ok    = wr_en  && (wr_addr  != '0) && !sweeping;
    assign rsv_ok   = rsv_en && (rsv_addr != '0) && !sweeping;
    assign last_cnt = (cnt_q == AW'(NREGS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RF_IDLE;
            cnt_q       <= '0;
            init_busy_q <= 1'b0;
        end else begin
            case (state_q)
                RF_IDLE: begin
                    if (init_req) begin
                        state_q     <= RF_SWEEP;
                        cnt_q       <= AW'(1);
                        init_busy_q <= 1'b1;
                    end
                end
                RF_SWEEP: begin
                    if (last_cnt) begin
                        state_q     <= RF_IDLE;
                        cnt_q       <= '0;
                        init_busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign init_busy = init_busy_q;

    always_comb begin
        regs_d = regs_q;
        if (sweeping)   regs_d[cnt_q]   = '0;
        else if (wr_ok) regs_d[wr_addr] = wr_data;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .clr_en   (sweeping || wr_ok),
        .clr_addr (sweeping ? cnt_q : wr_addr),
        .set_en   (rsv_ok),
        .set_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (busy_raw)
    );

    always_comb begin
        logic [AW-1:0] addr_k;
        addr_k  = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            addr_k = AW'(port_field(BUS_W'(rd_addr), k, AW));
            rd_data[k*XLEN +: XLEN] = regs_q[addr_k];
            rd_busy[k]              = busy_raw[k];
`ifdef REGFILE_BYPASS_EN
            // A reservation landing on the same register keeps the stored busy view.
            if (wr_ok && (addr_k == wr_addr)) begin
                rd_data[k*XLEN +: XLEN] = wr_data;
                if (!(rsv_ok && (rsv_addr == addr_k))) rd_busy[k] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb against an array-based reference model.
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                init_req;
    logic                init_busy;

    // Reference model: architectural contents, busy flags, next sweep index (0 = no sweep).
    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];
    int              m_sweep;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .init_req  (init_req),
        .init_busy (init_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_clock();
        if (reset) begin
            for (int a = 0; a < NREGS; a++) begin
                m_regs[a] = '0;
                m_busy[a] = 1'b0;
            end
            m_sweep = 0;
        end else if (m_sweep != 0) begin
            m_regs[m_sweep] = '0;
            m_busy[m_sweep] = 1'b0;
            m_sweep = (m_sweep == NREGS - 1) ? 0 : m_sweep + 1;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
            if (init_req) m_sweep = 1;
        end
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (m_sweep == 0 && wr_en && wr_addr != 0 && int'(wr_addr) == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (m_sweep == 0 && wr_en && wr_addr != 0 && int'(wr_addr) == a &&
            !(rsv_en && int'(rsv_addr) == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        init_req = 1'b0;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    function automatic logic [XLEN-1:0] port_data(input int k);
        return rd_data[k*XLEN +: XLEN];
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (init_busy !== 1'b0) $display("FAIL reset_init_busy: got %b expected 0", init_busy);
        else n_pass++;
        for (int a = 0; a < NREGS; a++) begin
            set_rd(0, a);
            set_rd(1, NREGS - 1 - a);
            #1;
            for (int k = 0; k < NRD; k++) begin
                n_checks++;
                if (port_data(k) !== '0 || rd_busy[k] !== 1'b0)
                    $display("FAIL reset_contents p%0d: got %h/%b expected 0/0", k, port_data(k), rd_busy[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        set_rd(0, 5); set_rd(1, 5);
        #1;
        for (int k = 0; k < NRD; k++) begin
            n_checks++;
            if (port_data(k) !== 32'hDEADBEEF)
                $display("FAIL write_r5 p%0d: got %h expected deadbeef", k, port_data(k));
            else n_pass++;
        end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        set_rd(0, 0); set_rd(1, 0);
        #1;
        for (int k = 0; k < NRD; k++) begin
            n_checks++;
            if (port_data(k) !== '0 || rd_busy[k] !== 1'b0)
                $display("FAIL write_r0 p%0d: got %h/%b expected 0/0", k, port_data(k), rd_busy[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reserve();
        idle_inputs();
        set_rd(0, 7); set_rd(1, 7);
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_busy !== 2'b11) $display("FAIL reserve_r7: got %b expected 11", rd_busy);
        else n_pass++;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_busy[0] !== 1'b0 || port_data(0) !== 32'h1234)
            $display("FAIL release_r7: got %h/%b expected 00001234/0", port_data(0), rd_busy[0]);
        else n_pass++;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h5555_AAAA;
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_busy[1] !== 1'b1 || port_data(1) !== 32'h5555_AAAA)
            $display("FAIL write_rsv_r7: got %h/%b expected 5555aaaa/1", port_data(1), rd_busy[1]);
        else n_pass++;
    endtask

    // Runs a sweep that is already underway, checking against the model each cycle.
    task automatic run_sweep(input string name, input int drop_at, output int cycles);
        cycles = 0;
        while (init_busy === 1'b1 && cycles < 100) begin
            wr_en    = (cycles == drop_at);
            wr_addr  = 5'd3;
            wr_data  = 32'hBAD0_0003;
            rsv_en   = (cycles == drop_at);
            rsv_addr = 5'd3;
            set_rd(0, 20);
            set_rd(1, (cycles + 1) % NREGS);
            #1;
            n_checks++;
            if (port_data(0) !== exp_data(20) || init_busy !== (m_sweep != 0))
                $display("FAIL %s_cycle%0d: got %h/%b expected %h/%b", name, cycles,
                         port_data(0), init_busy, exp_data(20), m_sweep != 0);
            else n_pass++;
            cycles++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_sweep();
        int cycles;
        idle_inputs();
        for (int a = 1; a < NREGS; a++) begin
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = $urandom | 32'h1;
            rsv_en = (a % 4 == 0); rsv_addr = AW'(a);
            tick();
        end
        idle_inputs();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        run_sweep("sweep", 5, cycles);
        n_checks++;
        if (cycles !== NREGS - 1) $display("FAIL sweep_length: got %0d expected %0d", cycles, NREGS - 1);
        else n_pass++;
        for (int a = 0; a < NREGS; a++) begin
            set_rd(0, a); set_rd(1, a);
            #1;
            n_checks++;
            if (port_data(0) !== '0 || port_data(1) !== '0 || rd_busy !== 2'b00)
                $display("FAIL sweep_zero_r%0d: got %h/%b expected 0/00", a, port_data(0), rd_busy);
            else n_pass++;
        end
    endtask

    task automatic test_sweep_reset();
        int cycles;
        idle_inputs();
        for (int a = 24; a < NREGS; a++) begin
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'hA5A5_0000 | a;
            rsv_en = 1'b1; rsv_addr = AW'(a);
            tick();
        end
        idle_inputs();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (init_busy !== 1'b0) $display("FAIL abort_init_busy: got %b expected 0", init_busy);
        else n_pass++;
        for (int a = 0; a < NREGS; a++) begin
            set_rd(0, a);
            #1;
            n_checks++;
            if (port_data(0) !== '0 || rd_busy[0] !== 1'b0)
                $display("FAIL abort_zero_r%0d: got %h/%b expected 0/0", a, port_data(0), rd_busy[0]);
            else n_pass++;
        end
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        run_sweep("resweep", -1, cycles);
        n_checks++;
        if (cycles !== NREGS - 1) $display("FAIL resweep_length: got %0d expected %0d", cycles, NREGS - 1);
        else n_pass++;
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] want_data;
        logic            want_busy;
        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1111_1111;
        tick();
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle_inputs();
        set_rd(0, 9); set_rd(1, 9);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
        #1;
`ifdef REGFILE_BYPASS_EN
        want_data = 32'hCAFEF00D; want_busy = 1'b0;
`else
        want_data = 32'h1111_1111; want_busy = 1'b1;
`endif
        for (int k = 0; k < NRD; k++) begin
            n_checks++;
            if (port_data(k) !== want_data || rd_busy[k] !== want_busy)
                $display("FAIL bypass_same_cycle p%0d: got %h/%b expected %h/%b", k,
                         port_data(k), rd_busy[k], want_data, want_busy);
            else n_pass++;
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (port_data(0) !== 32'hCAFEF00D || rd_busy[0] !== 1'b0)
            $display("FAIL bypass_next_cycle: got %h/%b expected cafef00d/0", port_data(0), rd_busy[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        int a;
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 79) == 0);
            init_req = ($urandom_range(0, 39) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            wr_addr  = AW'($urandom_range(0, NREGS - 1));
            wr_data  = $urandom;
            rsv_en   = $urandom_range(0, 2) == 0;
            rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
            set_rd(0, $urandom_range(0, NREGS - 1));
            set_rd(1, ($urandom_range(0, 1) == 1) ? int'(wr_addr) : $urandom_range(0, NREGS - 1));
            #1;
            for (int k = 0; k < NRD; k++) begin
                a = int'(rd_addr[k*AW +: AW]);
                n_checks++;
                if (port_data(k) !== exp_data(a) || rd_busy[k] !== exp_busy(a))
                    $display("FAIL random_i%0d_p%0d_r%0d: got %h/%b expected %h/%b", i, k, a,
                             port_data(k), rd_busy[k], exp_data(a), exp_busy(a));
                else n_pass++;
            end
            n_checks++;
            if (init_busy !== (m_sweep != 0))
                $display("FAIL random_init_busy_i%0d: got %b expected %b", i, init_busy, m_sweep != 0);
            else n_pass++;
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        m_sweep = 0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_reserve();
        test_sweep();
        test_sweep_reset();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
